// File: rtl/bit_field_packer_if.sv
// Field-in / word-out stream bundle for bit_field_packer.
// master = field producer and word sink side; slave = the packer.
interface bit_field_packer_if #(
    parameter int WIDTH = 16,
    parameter int LW    = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] in_data;
    logic [LW-1:0]    in_len;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    out_fill;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_len, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_fill, out_last, out_valid
    );

    modport slave (
        input  in_data, in_len, in_last, in_valid, out_ready,
        output in_ready, out_data, out_fill, out_last, out_valid
    );
endinterface

// File: rtl/bit_field_packer.sv
// Packs variable-width fields LSB-first into WIDTH-bit words, zero-padded flush at packet end.
// Latency: word completed by a beat at edge t is presented after edge t+1; one word per cycle.
// Backpressure: output held stable while stalled; in_ready drops once a full word is queued or during flush.
module bit_field_packer #(
    parameter int WIDTH = 16,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    bit_field_packer_if.slave bus
);
    localparam int AW = 2 * WIDTH - 1;
    localparam int CW = $clog2(2 * WIDTH);

    typedef enum logic {FILL, FLUSH} state_t;

    state_t           state;
    logic [AW-1:0]    acc;
    logic [CW-1:0]    count;

    logic             slot_free;
    logic             emit_full;
    logic             emit_part;
    logic             full_is_last;
    logic             accept;
    logic [LW-1:0]    len_c;
    logic [WIDTH-1:0] field;
    logic [AW-1:0]    acc_base;
    logic [AW-1:0]    acc_next;
    logic [CW-1:0]    count_base;
    logic [CW-1:0]    count_next;

    assign bus.in_ready = (state == FILL) && (count < CW'(WIDTH));
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        slot_free    = !bus.out_valid || bus.out_ready;
        emit_full    = slot_free && (count >= CW'(WIDTH));
        emit_part    = slot_free && (state == FLUSH) && (count < CW'(WIDTH));
        full_is_last = (state == FLUSH) && (count == CW'(WIDTH));

        len_c = (int'(bus.in_len) > WIDTH) ? LW'(WIDTH) : bus.in_len;
        field = bus.in_data & ~({WIDTH{1'b1}} << len_c);

        // Bits above count are always zero, so a partial word needs no extra masking.
        acc_base   = acc;
        count_base = count;
        if (emit_full) begin
            acc_base   = acc >> WIDTH;
            count_base = count - CW'(WIDTH);
        end else if (emit_part) begin
            acc_base   = '0;
            count_base = '0;
        end

        acc_next   = acc_base;
        count_next = count_base;
        if (accept) begin
            acc_next   = acc_base | (AW'(field) << count_base);
            count_next = count_base + CW'(len_c);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= FILL;
            acc           <= '0;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_fill  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            acc   <= acc_next;
            count <= count_next;

            if (emit_full) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= acc[WIDTH-1:0];
                bus.out_fill  <= LW'(WIDTH);
                bus.out_last  <= full_is_last;
            end else if (emit_part) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= acc[WIDTH-1:0];
                bus.out_fill  <= LW'(count);
                bus.out_last  <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (accept && bus.in_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (emit_part || (emit_full && full_is_last)) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_field_packer.sv
module tb_bit_field_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bit_field_packer_if #(.WIDTH(16)) bus ();

    bit_field_packer #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one beat and holds it until it is accepted at a clock edge.
    task automatic send(input logic [15:0] data, input logic [4:0] len, input logic last);
        int n;
        bus.in_data  = data;
        bus.in_len   = len;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed in_ready %b expected 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_len    = '0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_out_fill",  bus.out_fill,  0);
        check("rst_out_last",  bus.out_last,  0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", bus.in_ready, 1);

        // Four nibbles pack LSB-first
        send(16'h000A, 5'd4, 1'b0);
        send(16'h000B, 5'd4, 1'b0);
        send(16'h000C, 5'd4, 1'b0);
        send(16'h000D, 5'd4, 1'b0);
        check("nib_not_yet_valid", bus.out_valid, 0);
        step();
        check("nib_valid", bus.out_valid, 1);
        check("nib_data",  bus.out_data,  16'hDCBA);
        check("nib_fill",  bus.out_fill,  16);
        check("nib_last",  bus.out_last,  0);
        step();
        check("nib_drained", bus.out_valid, 0);

        // Word straddle then partial flush
        send(16'h0FFF, 5'd12, 1'b0);
        send(16'h005A, 5'd8,  1'b0);
        step();
        check("str_valid", bus.out_valid, 1);
        check("str_data",  bus.out_data,  16'hAFFF);
        check("str_fill",  bus.out_fill,  16);
        check("str_last",  bus.out_last,  0);
        send(16'h0000, 5'd0, 1'b1);
        check("flush_in_ready_low", bus.in_ready, 0);
        step();
        check("flush_valid", bus.out_valid, 1);
        check("flush_data",  bus.out_data,  16'h0005);
        check("flush_fill",  bus.out_fill,  4);
        check("flush_last",  bus.out_last,  1);
        check("flush_in_ready_high", bus.in_ready, 1);
        step();
        check("flush_drained", bus.out_valid, 0);

        // Exactly-full last field: no trailing partial word
        send(16'h1234, 5'd16, 1'b1);
        step();
        check("full_last_valid", bus.out_valid, 1);
        check("full_last_data",  bus.out_data,  16'h1234);
        check("full_last_fill",  bus.out_fill,  16);
        check("full_last_last",  bus.out_last,  1);
        step();
        check("full_last_no_trail", bus.out_valid, 0);
        check("full_last_in_ready", bus.in_ready, 1);

        // Backpressure
        send(16'h000A, 5'd4, 1'b0);
        send(16'h000B, 5'd4, 1'b0);
        send(16'h000C, 5'd4, 1'b0);
        send(16'h000D, 5'd4, 1'b0);
        bus.out_ready = 1'b0;
        step();
        check("bp_valid", bus.out_valid, 1);
        check("bp_data",  bus.out_data,  16'hDCBA);
        send(16'h0001, 5'd4, 1'b0);
        send(16'h0002, 5'd4, 1'b0);
        send(16'h0003, 5'd4, 1'b0);
        send(16'h0004, 5'd4, 1'b0);
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_hold_data", bus.out_data, 16'hDCBA);
        step();
        check("bp_hold_data2", bus.out_data, 16'hDCBA);
        check("bp_hold_valid", bus.out_valid, 1);
        check("bp_in_ready_low2", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        step();
        check("bp_next_valid", bus.out_valid, 1);
        check("bp_next_data",  bus.out_data,  16'h4321);
        check("bp_next_fill",  bus.out_fill,  16);
        step();
        check("bp_empty", bus.out_valid, 0);

        // Over-long length clamps to WIDTH
        send(16'hBEEF, 5'd20, 1'b1);
        step();
        check("clamp_data", bus.out_data, 16'hBEEF);
        check("clamp_fill", bus.out_fill, 16);
        check("clamp_last", bus.out_last, 1);
        step();
        check("clamp_no_trail", bus.out_valid, 0);

        // Empty packet
        send(16'hABCD, 5'd0, 1'b1);
        step();
        check("empty_valid", bus.out_valid, 1);
        check("empty_data",  bus.out_data,  0);
        check("empty_fill",  bus.out_fill,  0);
        check("empty_last",  bus.out_last,  1);
        step();

        // Reset during flush with 7 bits held
        bus.out_ready = 1'b0;
        send(16'h1111, 5'd16, 1'b0);
        send(16'hFFFF, 5'd7, 1'b1);
        check("rflush_in_ready_low", bus.in_ready, 0);
        check("rflush_held_data", bus.out_data, 16'h1111);
        rst_n = 1'b0;
        step();
        check("rflush_out_valid", bus.out_valid, 0);
        check("rflush_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(16'h0003, 5'd4, 1'b1);
        step();
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_data",  bus.out_data,  16'h0003);
        check("post_rst_fill",  bus.out_fill,  4);
        check("post_rst_last",  bus.out_last,  1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
